sa_multi_stream_gen: RTL and testbench
======================================

// Module: sa_multi_stream_gen
// PURPOSE
//  Multi-channel streaming-accurate (SA) bitstream generator.
//  - Encodes CH values k_c as k_c/2^N stochastic bitstreams by overflow-accumulation.
//  - Accepts a configurable stream length for early termination and stalls under output backpressure.
//  - Feeds the SC decompressor datapath; all channels share one beat index (one bus).
// PARAMETERS
//  N           7   value width; full stream length L = 2^N
//  CH          4   number of parallel channels
//  PHASE_MODE  0   0: every accumulator starts at L/2; 1: channel c starts at (L/2 + c*L/CH) mod L
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  cfg_valid  in   1      config offer
//  cfg_ready  out  1      high only in IDLE
//  cfg_k      in   CH*N   channel c value in bits [c*N +: N]
//  cfg_len    in   N+1    beats to emit, 1..L; 0 is treated as L; values > L are clamped to L
//  abort      in   1      synchronous abort of the current stream
//  bs_valid   out  1      beat available
//  bs_ready   in   1      beat accepted
//  bs_bits    out  CH     one stochastic bit per channel
//  bs_last    out  1      final beat of the stream
//  bs_idx     out  N      index of the current beat, 0..len-1
//  busy       out  1      high when not in IDLE
// BEHAVIOUR
//  Reset values
//  - state=IDLE; accumulators=L/2; k regs=0; len reg=L; idx=0.
//  - bs_valid=0, bs_bits=0, bs_last=0, bs_idx=0, busy=0; cfg_ready=1 during and after reset.
//  FSM IDLE -> RUN
//  - cfg_valid & cfg_ready latches k, len and phase-init accumulators.
//  - RUN is entered on the next edge; first beat is offered 1 cycle after the handshake.
//  FSM RUN
//  - bs_valid=1. bs_bits[c] = carry-out of acc_c + k_c (N+1-bit sum).
//  - Bits depend only on registered state, never on bs_ready.
//  - Transfer (bs_valid & bs_ready): acc_c <= sum[N-1:0] (mod 2^N), idx++.
//  - No transfer: acc, idx and bs_bits hold stable.
//  - bs_last = (idx == len-1). A transfer with bs_last returns to IDLE.
//  - cfg_ready stays low in RUN; one IDLE bubble between streams.
//  Abort
//  - From any state: next state IDLE, idx=0, accumulators re-init.
//  - bs_last is not emitted. Abort wins over a same-cycle transfer or cfg handshake.
//  Outputs outside RUN
//  - bs_bits, bs_last and bs_idx are forced to 0 whenever bs_valid=0.
//  Boundary cases
//  - k=0: all zeros.
//  - len=1: single beat with bs_last=1.
//  - idx never wraps; max idx is L-1 when len=L.
//  SA guarantee (PHASE_MODE=0)
//  - Ones on channel c after t beats = floor((L/2 + t*k_c)/L) for every t <= len.
//  Reset mid-stream
//  - Asynchronous return to reset values; no partial beat completes.
// STRUCTURE
//  Shared package sa_pkg
//  - State encoding (IDLE, RUN).
//  - Function sa_phase_init(c, N, CH, mode) returning the init value.
//  - L_HALF constant.
//  Sub-module sa_channel (one per channel, generate loop)
//  - N-bit accumulator, k register, adder, carry output.
//  - Inputs load, init_val, advance.
//  Top level
//  - FSM, len/idx counter, handshake logic, output gating.
// TESTING  (N=7, CH=4 unless noted)
//  1. Reset and idle
//     - Reset asserted mid-RUN -> bs_valid=0, cfg_ready=1, acc=64 immediately.
//     - After release, first cfg handshake starts the stream cleanly.
//  2. Full-length streams
//     - k={64,0,127,1}, len=0 (L), bs_ready=1.
//     - ch0 alternates 1,0,1,0...; ch1 all 0.
//     - ch2 is 1 for idx 0..63, 0 at idx 64.
//     - ch3 has a single 1 at idx 63.
//     - bs_last at idx 127.
//  3. Early termination
//     - k0=32, len=10 -> ch0 ones at idx 1,5,9 only (3 ones); bs_last at idx 9.
//     - Next cycle: busy=0, cfg_ready=1.
//  4. Backpressure
//     - Random bs_ready (~50%) with k0=96.
//     - Bit sequence identical to the bs_ready=1 run; bits/idx stable while stalled.
//  5. Abort
//     - Abort at idx 20 together with bs_ready=1 -> no bs_last, IDLE next cycle.
//     - Restart with the same cfg reproduces beats from idx 0.
//  6. Phase mode
//     - PHASE_MODE=1, all k=64 -> initial acc {64,96,0,32}.
//     - First-beat bits {1,1,0,0}.
//     - Ones counts after 128 beats all equal 64.

Source files
------------

// File: rtl/sa_multi_stream_gen_pkg.sv
// Shared types and helpers for the multi-channel SA bitstream generator.
package sa_multi_stream_gen_pkg;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    localparam int unsigned DEF_N  = 7;
    localparam int unsigned L_HALF = 1 << (DEF_N - 1);

    // Accumulator start value for channel c; mode 1 staggers channels evenly around the ring.
    function automatic int unsigned sa_phase_init(int unsigned c, int unsigned n,
                                                  int unsigned ch, int unsigned mode);
        int unsigned l;
        l = 1 << n;
        if (mode == 0) begin
            return l / 2;
        end
        return (l / 2 + (c * l) / ch) % l;
    endfunction

endpackage

// File: rtl/sa_multi_stream_gen_if.sv
// Beat bus from the SA generator to the decompressor datapath.
interface sa_multi_stream_gen_if #(
    parameter int unsigned N  = 7,
    parameter int unsigned CH = 4
) ();

    logic          bs_valid;
    logic          bs_ready;
    logic [CH-1:0] bs_bits;
    logic          bs_last;
    logic [N-1:0]  bs_idx;

    modport master (
        output bs_valid,
        output bs_bits,
        output bs_last,
        output bs_idx,
        input  bs_ready
    );

    modport slave (
        input  bs_valid,
        input  bs_bits,
        input  bs_last,
        input  bs_idx,
        output bs_ready
    );

endinterface

// File: rtl/sa_multi_stream_gen_channel.sv
// One SA channel: k register plus overflow accumulator; the carry is the stochastic bit.
module sa_multi_stream_gen_channel #(
    parameter int unsigned N = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         reinit,
    input  logic         advance,
    input  logic [N-1:0] k,
    input  logic [N-1:0] init_val,
    output logic         carry
);

    localparam logic [N-1:0] AccRst = {1'b1, {(N - 1){1'b0}}};

    logic [N-1:0] acc_q;
    logic [N-1:0] k_q;
    logic [N:0]   sum;

    assign sum   = {1'b0, acc_q} + {1'b0, k_q};
    assign carry = sum[N];

    // Reinit (abort) outranks a same-cycle load or advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= AccRst;
            k_q   <= '0;
        end else if (reinit) begin
            acc_q <= init_val;
        end else if (load) begin
            k_q   <= k;
            acc_q <= init_val;
        end else if (advance) begin
            acc_q <= sum[N-1:0];
        end
    end

endmodule

// File: rtl/sa_multi_stream_gen.sv
// Multi-channel streaming-accurate bitstream generator: CH channels share one beat index.
module sa_multi_stream_gen
    import sa_multi_stream_gen_pkg::*;
#(
    parameter int unsigned N          = 7,
    parameter int unsigned CH         = 4,
    parameter int unsigned PHASE_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH*N-1:0]      cfg_k,
    input  logic [N:0]           cfg_len,
    input  logic                 abort,
    sa_multi_stream_gen_if.master bs,
    output logic                 busy
);

    localparam logic [N:0] LenFull = {1'b1, {N{1'b0}}};

    state_e        state_q;
    logic [N:0]    len_q;
    logic [N-1:0]  idx_q;
    logic [N:0]    len_eff;
    logic [CH-1:0] raw_bits;
    logic          run;
    logic          last;
    logic          load;
    logic          advance;

    assign run     = (state_q == StRun);
    assign last    = ({1'b0, idx_q} == (len_q - 1'b1));
    assign load    = cfg_valid & ~run & ~abort;
    assign advance = run & bs.bs_ready & ~abort;
    assign len_eff = (cfg_len == '0 || cfg_len > LenFull) ? LenFull : cfg_len;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        localparam logic [N-1:0] Init = N'(sa_phase_init(c, N, CH, PHASE_MODE));

        sa_multi_stream_gen_channel #(
            .N (N)
        ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load),
            .reinit   (abort),
            .advance  (advance),
            .k        (cfg_k[c*N +: N]),
            .init_val (Init),
            .carry    (raw_bits[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            len_q   <= LenFull;
            idx_q   <= '0;
        end else if (abort) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfg_valid) begin
                        len_q   <= len_eff;
                        idx_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (bs.bs_ready) begin
                        if (last) begin
                            idx_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Bus fields are zeroed whenever no beat is offered.
    assign bs.bs_valid = run;
    assign bs.bs_bits  = run ? raw_bits : '0;
    assign bs.bs_last  = run & last;
    assign bs.bs_idx   = run ? idx_q : '0;
    assign cfg_ready   = ~run;
    assign busy        = run;

endmodule

// File: tb/tb_sa_multi_stream_gen.sv
// Self-checking bench: table of streams against an SA scoreboard plus corner-case sequences.
module tb_sa_multi_stream_gen;
    import sa_multi_stream_gen_pkg::*;

    localparam int unsigned N  = 7;
    localparam int unsigned CH = 4;
    localparam int unsigned L  = 128;

    typedef struct packed {
        logic [CH-1:0] bits;
        logic [N-1:0]  idx;
        logic          last;
    } beat_t;

    typedef struct {
        logic [CH*N-1:0]     k;
        logic [N:0]          len;
        bit                  rnd;
        int                  beats;
        logic [CH-1:0][7:0]  ones;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic cfg_valid = 1'b0;
    logic cfg1_valid = 1'b0;
    logic abort = 1'b0;
    logic [CH*N-1:0] cfg_k = '0;
    logic [N:0] cfg_len = '0;
    logic cfg_ready, busy, cfg1_ready, busy1;

    sa_multi_stream_gen_if #(.N(N), .CH(CH)) bs0 ();
    sa_multi_stream_gen_if #(.N(N), .CH(CH)) bs1 ();

    sa_multi_stream_gen #(.N(N), .CH(CH), .PHASE_MODE(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_k     (cfg_k),
        .cfg_len   (cfg_len),
        .abort     (abort),
        .bs        (bs0),
        .busy      (busy)
    );

    sa_multi_stream_gen #(.N(N), .CH(CH), .PHASE_MODE(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg1_valid),
        .cfg_ready (cfg1_ready),
        .cfg_k     (cfg_k),
        .cfg_len   (cfg_len),
        .abort     (1'b0),
        .bs        (bs1),
        .busy      (busy1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    beat_t exp_q[$];
    int ones[CH];
    int beats_seen;
    bit rnd_mode = 1'b0;
    logic stall_prev = 1'b0;
    logic [CH+N-1:0] stall_val;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [CH*N-1:0] pk(int a, int b, int c, int d);
        return {7'(d), 7'(c), 7'(b), 7'(a)};
    endfunction

    function automatic vec_t mk(logic [CH*N-1:0] k, int len, bit rnd, int beats,
                                int o0, int o1, int o2, int o3);
        vec_t v;
        v.k       = k;
        v.len     = (N + 1)'(len);
        v.rnd     = rnd;
        v.beats   = beats;
        v.ones[0] = 8'(o0);
        v.ones[1] = 8'(o1);
        v.ones[2] = 8'(o2);
        v.ones[3] = 8'(o3);
        return v;
    endfunction

    // Reference SA encoder with accumulators starting at L/2.
    task automatic push_model(logic [CH*N-1:0] k, int beats);
        int acc[CH];
        beat_t b;
        for (int c = 0; c < CH; c++) acc[c] = L_HALF;
        for (int i = 0; i < beats; i++) begin
            for (int c = 0; c < CH; c++) begin
                int s;
                s = acc[c] + int'(k[c*N +: N]);
                b.bits[c] = (s >= int'(L));
                acc[c] = s % int'(L);
            end
            b.idx  = N'(i);
            b.last = (i == beats - 1);
            exp_q.push_back(b);
        end
    endtask

    initial begin
        bs1.bs_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bs0.bs_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bs0.bs_valid && bs0.bs_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat", {bs0.bs_bits, bs0.bs_idx, bs0.bs_last}, e);
                    for (int c = 0; c < CH; c++) ones[c] += int'(bs0.bs_bits[c]);
                    beats_seen++;
                end
            end
            if (!bs0.bs_valid) begin
                check("idle_gating", {bs0.bs_bits, bs0.bs_idx, bs0.bs_last}, 0);
            end
            if (stall_prev && bs0.bs_valid) begin
                check("stall_hold", {bs0.bs_bits, bs0.bs_idx}, stall_val);
            end
            stall_prev = bs0.bs_valid & ~bs0.bs_ready & ~abort;
            stall_val  = {bs0.bs_bits, bs0.bs_idx};
        end
    end

    task automatic start_stream(logic [CH*N-1:0] k, logic [N:0] len, int beats, bit rnd);
        rnd_mode   = rnd;
        beats_seen = 0;
        for (int c = 0; c < CH; c++) ones[c] = 0;
        @(posedge clk);
        #1;
        check("cfg_ready_idle", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_k     = k;
        cfg_len   = len;
        push_model(k, beats);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        check("busy_after_cfg", busy, 1);
    endtask

    task automatic run_vec(vec_t v);
        int n;
        start_stream(v.k, v.len, v.beats, v.rnd);
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        check("beat_count", beats_seen, v.beats);
        for (int c = 0; c < CH; c++) check("ones_count", ones[c], int'(v.ones[c]));
        check("busy_after_last", busy, 0);
        check("cfg_ready_after_last", cfg_ready, 1);
        rnd_mode = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(pk(64, 0, 127, 1),    0,   1'b0, 128, 64, 0, 127, 1);
        vecs[1] = mk(pk(32, 0, 0, 0),      10,  1'b0, 10,  3, 0, 0, 0);
        vecs[2] = mk(pk(96, 5, 50, 127),   0,   1'b1, 128, 96, 5, 50, 127);
        vecs[3] = mk(pk(96, 5, 50, 127),   200, 1'b0, 128, 96, 5, 50, 127);
        vecs[4] = mk(pk(127, 64, 63, 0),   1,   1'b1, 1,   1, 1, 0, 0);
        vecs[5] = mk(pk(0, 0, 0, 0),       37,  1'b1, 37,  0, 0, 0, 0);
        vecs[6] = mk(pk(1, 2, 3, 4),       128, 1'b0, 128, 1, 2, 3, 4);
        vecs[7] = mk(pk(32, 100, 7, 120),  10,  1'b1, 10,  3, 8, 1, 9);

        #1 rst_n = 1'b0;
        #1;
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", bs0.bs_valid, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Asynchronous reset in the middle of a stream.
        start_stream(pk(64, 0, 127, 1), 0, 128, 1'b0);
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", bs0.bs_valid, 0);
        check("midrst_cfg_ready", cfg_ready, 1);
        check("midrst_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_vec(vecs[0]);

        // Abort at idx 20 while the sink is ready.
        begin
            int n;
            start_stream(pk(96, 5, 50, 127), 0, 128, 1'b0);
            n = 0;
            while (!(bs0.bs_valid && bs0.bs_idx == 20) && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("abort_reach_idx20", bs0.bs_idx, 20);
            abort = 1'b1;
            #1;
            check("abort_no_last", bs0.bs_last, 0);
            @(posedge clk);
            #1;
            abort = 1'b0;
            check("abort_valid", bs0.bs_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_cfg_ready", cfg_ready, 1);
            check("abort_remaining", exp_q.size(), 108);
            exp_q.delete();
            run_vec(vecs[2]);
        end

        // Abort beats a same-cycle config handshake.
        @(posedge clk);
        #1;
        cfg_valid = 1'b1;
        abort     = 1'b1;
        cfg_k     = pk(64, 64, 64, 64);
        cfg_len   = 5;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        abort     = 1'b0;
        check("abort_cfg_busy", busy, 0);
        check("abort_cfg_valid", bs0.bs_valid, 0);

        // Staggered phases on the PHASE_MODE=1 instance.
        begin
            int n;
            int ph_ones[CH];
            for (int c = 0; c < CH; c++) ph_ones[c] = 0;
            @(posedge clk);
            #1;
            cfg_k      = pk(64, 64, 64, 64);
            cfg_len    = 0;
            cfg1_valid = 1'b1;
            @(posedge clk);
            #1;
            cfg1_valid = 1'b0;
            n = 0;
            for (int cyc = 0; cyc < 300; cyc++) begin
                @(negedge clk);
                if (bs1.bs_valid) begin
                    if (n == 0) check("phase_first_bits", bs1.bs_bits, 4'b0011);
                    for (int c = 0; c < CH; c++) ph_ones[c] += int'(bs1.bs_bits[c]);
                    n++;
                end else if (n > 0) begin
                    break;
                end
            end
            check("phase_beats", n, 128);
            for (int c = 0; c < CH; c++) check("phase_ones", ph_ones[c], 64);
            check("phase_idle", busy1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
